// File: rtl/dsram_responder.sv
// Data-SRAM responder: accepts one byte-masked request at a time, waits
// WAIT_CYCLES, then commits byte-lane writes or returns the aligned word.
module dsram_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic [3:0]         wen_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               data_ok_q;
    logic               busy_q;
    logic [31:0]        rdata_q;
    logic [31:0]        mem_q [0:DEPTH-1];

    logic               commit_d;
    logic [3:0]         wen_d;
    logic [ADDR_W-1:0]  idx_d;
    logic [31:0]        wdata_d;
    logic               unused_addr;

    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    // With zero wait states the acceptance edge is also the commit edge,
    // so the request fields come straight from the inputs.
    always_comb begin
        commit_d = 1'b0;
        wen_d    = wen_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        if (ZERO_WAIT) begin
            if (state_q == S_IDLE && req) begin
                commit_d = resetn;
                wen_d    = wen;
                idx_d    = addr[ADDR_W+1:2];
                wdata_d  = wdata;
            end
        end else if (state_q == S_WAIT && cnt_q == 3'd1) begin
            commit_d = resetn;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_d && wen_d != '0) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wen_d[b]) begin
                    mem_q[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wen_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            data_ok_q <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (commit_d && wen_d == '0) begin
                rdata_q <= mem_q[idx_d];
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        wen_q   <= wen;
                        idx_q   <= addr[ADDR_W+1:2];
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (ZERO_WAIT) begin
                            cnt_q     <= '0;
                            state_q   <= S_RESP;
                            data_ok_q <= 1'b1;
                        end else begin
                            cnt_q   <= WAIT_INIT;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q   <= S_RESP;
                        data_ok_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    data_ok_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    data_ok_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign addr_ok = (state_q == S_IDLE);
    assign data_ok = data_ok_q;
    assign busy    = busy_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Randomized and directed bench for dsram_responder; three instances cover
// one, zero and three wait states against a word/byte-lane reference model.
module tb_dsram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  req_v;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  aok, dok, bsy;
    logic [31:0] rd0, rd1, rd2;

    int total = 0;
    int bad   = 0;

    // Reference model: word contents plus which byte lanes have ever been written.
    logic [31:0] m_word  [3][1024];
    logic [3:0]  m_known [3][1024];

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .resetn(resetn), .req(req_v[0]), .wen(wen), .addr(addr), .wdata(wdata),
        .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd0), .busy(bsy[0]));
    dsram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .resetn(resetn), .req(req_v[1]), .wen(wen), .addr(addr), .wdata(wdata),
        .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd1), .busy(bsy[1]));
    dsram_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .resetn(resetn), .req(req_v[2]), .wen(wen), .addr(addr), .wdata(wdata),
        .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd2), .busy(bsy[2]));

    function automatic int wc(input int i);
        case (i)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        case (i)
            0: return rd0;
            1: return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 1024);
    endfunction

    function automatic void model_write(input int i, input logic [3:0] w,
                                        input logic [31:0] a, input logic [31:0] d);
        int k;
        k = widx(a);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) begin
                m_word[i][k][8*b +: 8] = d[8*b +: 8];
                m_known[i][k][b] = 1'b1;
            end
        end
    endfunction

    // Issues one request on instance i; reports latency (edges from acceptance
    // to the first sample with data_ok), rdata during data_ok, addr_ok during
    // data_ok, and whether the pulse lasted exactly one cycle then went idle.
    task automatic do_txn(input int i, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r, output int lat,
                          output bit aok_resp, output bit one_cyc);
        int n;
        @(negedge clk);
        wen = w; addr = a; wdata = d; req_v[i] = 1'b1;
        n = 0;
        while (!aok[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d: addr_ok=%b want 1", i, aok[i]);
            req_v[i] = 1'b0; r = '0; lat = -1; aok_resp = 1'b1; one_cyc = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_v[i] = 1'b0;
        wen = 4'($urandom); addr = $urandom; wdata = $urandom;
        lat = 0;
        while (!dok[i] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = get_rd(i);
        aok_resp = aok[i];
        @(posedge clk);
        #1;
        one_cyc = !dok[i] && aok[i] && !bsy[i];
        if (w != 4'b0000) model_write(i, w, a, d);
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_v = '0; wen = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++; if (aok[i] !== 1'b1) begin bad++; $display("FAIL reset_addr_ok inst=%0d: got %b want 1", i, aok[i]); end
            total++; if (dok[i] !== 1'b0) begin bad++; $display("FAIL reset_data_ok inst=%0d: got %b want 0", i, dok[i]); end
            total++; if (bsy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy inst=%0d: got %b want 0", i, bsy[i]); end
            total++; if (get_rd(i) !== 32'h0) begin bad++; $display("FAIL reset_rdata inst=%0d: got %h want 0", i, get_rd(i)); end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] r; int lat; bit ar, oc;
        do_txn(0, 4'b1111, 32'h100, 32'hDEADBEEF, r, lat, ar, oc);
        total++; if (lat != 1) begin bad++; $display("FAIL full_wr_latency: got %0d want 1", lat); end
        total++; if (!oc) begin bad++; $display("FAIL full_wr_pulse: got %b want 1", oc); end
        total++; if (ar) begin bad++; $display("FAIL full_wr_addr_ok_in_resp: got %b want 0", ar); end
        do_txn(0, 4'b0000, 32'h100, 32'h0, r, lat, ar, oc);
        total++; if (lat != 1) begin bad++; $display("FAIL full_rd_latency: got %0d want 1", lat); end
        total++; if (r !== 32'hDEADBEEF) begin bad++; $display("FAIL full_rd_data: got %h want deadbeef", r); end
        total++; if (!oc) begin bad++; $display("FAIL full_rd_pulse: got %b want 1", oc); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] r; int lat; bit ar, oc;
        do_txn(0, 4'b1111, 32'h20, 32'h11223344, r, lat, ar, oc);
        do_txn(0, 4'b0100, 32'h20, 32'hAAAAAAAA, r, lat, ar, oc);
        do_txn(0, 4'b0000, 32'h20, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h11AA3344) begin bad++; $display("FAIL lane_0100: got %h want 11aa3344", r); end
        do_txn(0, 4'b0011, 32'h20, 32'h55665566, r, lat, ar, oc);
        total++; if (rd0 !== 32'h11AA3344) begin bad++; $display("FAIL rdata_hold_on_write: got %h want 11aa3344", rd0); end
        do_txn(0, 4'b0000, 32'h20, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h11AA5566) begin bad++; $display("FAIL lane_0011: got %h want 11aa5566", r); end
        do_txn(0, 4'b0110, 32'h22, 32'h0BCDEF00, r, lat, ar, oc);
        do_txn(0, 4'b0000, 32'h20, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h11CDEF66) begin bad++; $display("FAIL lane_0110: got %h want 11cdef66", r); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] r, v; int lat; bit ar, oc;
        v = $urandom;
        do_txn(1, 4'b1111, 32'h40, v, r, lat, ar, oc);
        total++; if (lat != 0) begin bad++; $display("FAIL zw_wr_latency: got %0d want 0", lat); end
        do_txn(1, 4'b0000, 32'h40, 32'h0, r, lat, ar, oc);
        total++; if (lat != 0) begin bad++; $display("FAIL zw_rd_latency: got %0d want 0", lat); end
        total++; if (ar) begin bad++; $display("FAIL zw_addr_ok_in_resp: got %b want 0", ar); end
        total++; if (!oc) begin bad++; $display("FAIL zw_addr_ok_after: got %b want 1", oc); end
        total++; if (r !== v) begin bad++; $display("FAIL zw_rd_data: got %h want %h", r, v); end
    endtask

    task automatic test_held_req();
        logic [31:0] r; int lat; bit ar, oc;
        int first, second; bit seen_idle, dropped;
        first = -1; second = -1; seen_idle = 1'b0; dropped = 1'b0;
        @(negedge clk);
        wen = 4'b1111; addr = 32'h200; wdata = 32'hA5A50F0F; req_v[0] = 1'b1;
        @(posedge clk);
        #1;
        addr = 32'h204; wdata = 32'h1234ABCD;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (dok[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (aok[0]) seen_idle = 1'b1;
            else if (seen_idle && !dropped) begin
                req_v[0] = 1'b0;
                dropped = 1'b1;
            end
            if (second >= 0) break;
        end
        req_v[0] = 1'b0;
        model_write(0, 4'b1111, 32'h200, 32'hA5A50F0F);
        model_write(0, 4'b1111, 32'h204, 32'h1234ABCD);
        total++; if (first != wc(0)) begin bad++; $display("FAIL held_first_done: got %0d want %0d", first, wc(0)); end
        total++; if (second != 2 * wc(0) + 2) begin bad++; $display("FAIL held_second_done: got %0d want %0d", second, 2 * wc(0) + 2); end
        @(posedge clk);
        do_txn(0, 4'b0000, 32'h200, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'hA5A50F0F) begin bad++; $display("FAIL held_latched_word: got %h want a5a50f0f", r); end
        do_txn(0, 4'b0000, 32'h204, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h1234ABCD) begin bad++; $display("FAIL held_second_word: got %h want 1234abcd", r); end
    endtask

    task automatic test_index_wrap();
        logic [31:0] r; int lat; bit ar, oc;
        do_txn(0, 4'b1111, 32'h1000, 32'h12345678, r, lat, ar, oc);
        do_txn(0, 4'b0000, 32'h0, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h12345678) begin bad++; $display("FAIL wrap_idx0: got %h want 12345678", r); end
        do_txn(0, 4'b0000, 32'h3, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h12345678) begin bad++; $display("FAIL unaligned_read: got %h want 12345678", r); end
    endtask

    task automatic test_random();
        logic [31:0] r, a, d; logic [3:0] w; int lat, i, k; bit ar, oc;
        for (int p = 0; p < 3; p++) begin
            for (int q = 0; q < 8; q++) begin
                do_txn(p, 4'b1111, 32'(32'h300 + 4 * q), $urandom, r, lat, ar, oc);
            end
        end
        for (int n = 0; n < 45; n++) begin
            i = int'($urandom_range(0, 2));
            k = 32'h0C0 + int'($urandom_range(0, 7));
            a = ($urandom & 32'hFFFFF003) | 32'(k << 2);
            w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            d = $urandom;
            do_txn(i, w, a, d, r, lat, ar, oc);
            total++; if (lat != wc(i)) begin bad++; $display("FAIL rnd_latency n=%0d inst=%0d: got %0d want %0d", n, i, lat, wc(i)); end
            total++; if (!oc || ar) begin bad++; $display("FAIL rnd_pulse n=%0d inst=%0d: got one_cyc=%b aok=%b want 1/0", n, i, oc, ar); end
            if (w == 4'b0000 && m_known[i][widx(a)] == 4'hF) begin
                total++;
                if (r !== m_word[i][widx(a)]) begin
                    bad++;
                    $display("FAIL rnd_read n=%0d inst=%0d addr=%h: got %h want %h", n, i, a, r, m_word[i][widx(a)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] r; int lat, n; bit ar, oc;
        do_txn(2, 4'b1111, 32'h8, 32'h0, r, lat, ar, oc);
        @(negedge clk);
        wen = 4'b1111; addr = 32'h8; wdata = 32'hFFFFFFFF; req_v[2] = 1'b1;
        @(posedge clk);
        #1;
        req_v[2] = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bsy[2] !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", bsy[2]); end
        resetn = 1'b0;
        #1;
        total++; if (dok[2] !== 1'b0) begin bad++; $display("FAIL rst_wait_data_ok: got %b want 0", dok[2]); end
        total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL rst_wait_rdata: got %h want 0", rd2); end
        total++; if (aok[2] !== 1'b1) begin bad++; $display("FAIL rst_wait_addr_ok: got %b want 1", aok[2]); end
        @(negedge clk);
        resetn = 1'b1;
        do_txn(2, 4'b0000, 32'h8, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rst_dropped_write: got %h want 0", r); end

        @(negedge clk);
        wen = 4'b1111; addr = 32'h10; wdata = 32'hCAFE0001; req_v[2] = 1'b1;
        @(posedge clk);
        #1;
        req_v[2] = 1'b0;
        n = 0;
        while (!dok[2] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        resetn = 1'b0;
        #1;
        total++; if (dok[2] !== 1'b0) begin bad++; $display("FAIL rst_resp_data_ok: got %b want 0", dok[2]); end
        @(negedge clk);
        resetn = 1'b1;
        model_write(2, 4'b1111, 32'h10, 32'hCAFE0001);
        do_txn(2, 4'b0000, 32'h10, 32'h0, r, lat, ar, oc);
        total++; if (r !== 32'hCAFE0001) begin bad++; $display("FAIL rst_committed_write: got %h want cafe0001", r); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 1024; k++) begin
                m_word[i][k] = '0;
                m_known[i][k] = '0;
            end
        end
        test_reset();
        test_full_word();
        test_byte_lanes();
        test_zero_wait();
        test_held_req();
        test_index_wrap();
        test_random();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
